// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pkg
//  Description : Shared binary32 definitions for the fp_square / sqrt
//                datapath: format constants, FSM state encoding,
//                operand class type and an operand classifier.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF    = 32'h7F80_0000;

    // Iterative-unit state encoding, shared with sqrt.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_PACK = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MUL  = ST_MUL,
        S_NORM = ST_NORM,
        S_PACK = ST_PACK
    } fp_state_e;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    // Subnormals are classified as zero: they are flushed.
    function automatic fp_class_e fp_classify(input logic [7:0]  e,
                                              input logic [22:0] f);
        if (e == 8'd0)
            return CLS_ZERO;
        if (e == 8'(FP_EXP_MAX))
            return (f != 23'd0) ? CLS_NAN : CLS_INF;
        return CLS_NORMAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Combinational round-to-nearest-even and pack of a binary32
//                result, with overflow to inf, underflow flush to zero and
//                special-class override.
//  Ports       : mant_i   [22:0] kept mantissa (hidden bit excluded)
//                guard_i         first discarded bit
//                sticky_i        OR of all lower discarded bits
//                exp_i    [9:0]  biased exponent, two's complement
//                sign_i          result sign for non-NaN results
//                cls_i           operand class (overrides the packed value)
//                result_o [31:0] packed binary32 result
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack
    import fp32_pkg::*;
(
    input  logic [22:0] mant_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    input  logic [9:0]  exp_i,
    input  logic        sign_i,
    input  fp_class_e   cls_i,
    output logic [31:0] result_o
);

    logic        w_inc;
    logic [23:0] w_sum;
    logic [9:0]  w_exp;

    assign w_inc = guard_i & (sticky_i | mant_i[0]);
    // A carry out leaves w_sum[22:0] all zero, so only the exponent moves.
    assign w_sum = {1'b0, mant_i} + {23'd0, w_inc};
    assign w_exp = exp_i + {9'd0, w_sum[23]};

    always_comb begin
        result_o = {sign_i, w_exp[7:0], w_sum[22:0]};
        if ($signed(w_exp) >= $signed(10'(FP_EXP_MAX)))
            result_o = {sign_i, FP_PINF[30:0]};
        else if ($signed(w_exp) <= $signed(10'd0))
            result_o = {sign_i, 31'd0};

        case (cls_i)
            CLS_ZERO: result_o = {sign_i, 31'd0};
            CLS_INF:  result_o = {sign_i, FP_PINF[30:0]};
            CLS_NAN:  result_o = FP_QNAN;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fp_square.sv
`default_nettype none
// ============================================================================
//  Module      : fp_square
//  Description : Iterative IEEE-754 binary32 squarer. Shift-add mantissa
//                multiply, RNE rounding, start/done handshake with constant
//                latency (26 cycles radix-2, 14 cycles radix-4).
//  Macro       : FP_SQUARE_RADIX4_EN - two multiplier bits per MUL cycle.
//  Ports       : CLK          clock, rising edge
//                RST          synchronous active-low reset
//                start        request, sampled only in IDLE
//                x     [31:0] operand, captured on accept
//                sq    [31:0] result, updated with done and then held
//                done         one-cycle result-valid pulse
//                busy         high from accept until done rises
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_square
    import fp32_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] x,
    output logic [31:0] sq,
    output logic        done,
    output logic        busy
);

`ifdef FP_SQUARE_RADIX4_EN
    localparam int CNT_W    = 4;
    localparam int LAST_CNT = 11;
`else
    localparam int CNT_W    = 5;
    localparam int LAST_CNT = 23;
`endif

    logic [1:0]       state_q, state_d;
    logic [47:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exp_q;
    logic [23:0]      m_q;
    logic             sign_q;
    fp_class_e        cls_q;
    logic [22:0]      kept_q;
    logic             guard_q;
    logic             sticky_q;
    logic [9:0]       er_q;
    logic [31:0]      sq_q;
    logic             done_q;
    logic             busy_q;

    logic             w_accept;
    logic [23:0]      w_m_in;
    logic [47:0]      w_addend;
    logic             w_last;
    logic             w_n;
    logic [31:0]      w_packed;

    assign w_accept = (state_q == ST_IDLE) && start;
    assign w_m_in   = {1'b1, x[22:0]};
    assign w_last   = (cnt_q == CNT_W'(LAST_CNT));

`ifdef FP_SQUARE_RADIX4_EN
    logic [25:0] m3_q;
    logic [1:0]  w_digit;
    logic [47:0] w_part;

    assign w_digit = {m_q[{cnt_q, 1'b1}], m_q[{cnt_q, 1'b0}]};

    always_comb begin
        case (w_digit)
            2'd1:    w_part = {24'd0, m_q};
            2'd2:    w_part = {23'd0, m_q, 1'b0};
            2'd3:    w_part = {22'd0, m3_q};
            default: w_part = 48'd0;
        endcase
    end

    assign w_addend = w_part << {cnt_q, 1'b0};
`else
    assign w_addend = m_q[cnt_q] ? ({24'd0, m_q} << cnt_q) : 48'd0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MUL;
                    acc_d   = 48'd0;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                acc_d = acc_q + w_addend;
                cnt_d = cnt_q + CNT_W'(1);
                if (w_last)
                    state_d = ST_NORM;
            end
            ST_NORM: state_d = ST_PACK;
            ST_PACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Product of two values in [1,2) lies in [1,4): bit 47 says which half.
    assign w_n = acc_q[47];

    fp_round_pack u_round_pack (
        .mant_i   (kept_q),
        .guard_i  (guard_q),
        .sticky_i (sticky_q),
        .exp_i    (er_q),
        // Product sign is sign(x) XOR sign(x), i.e. always positive.
        .sign_i   (sign_q ^ sign_q),
        .cls_i    (cls_q),
        .result_o (w_packed)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            acc_q    <= 48'd0;
            cnt_q    <= '0;
            exp_q    <= 8'd0;
            m_q      <= 24'd0;
            sign_q   <= 1'b0;
            cls_q    <= CLS_ZERO;
            kept_q   <= 23'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            er_q     <= 10'd0;
            sq_q     <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FP_SQUARE_RADIX4_EN
            m3_q     <= 26'd0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= 1'b0;

            if (w_accept) begin
                exp_q  <= x[30:23];
                m_q    <= w_m_in;
                sign_q <= x[31];
                cls_q  <= fp_classify(x[30:23], x[22:0]);
                busy_q <= 1'b1;
`ifdef FP_SQUARE_RADIX4_EN
                m3_q   <= {2'b00, w_m_in} + {1'b0, w_m_in, 1'b0};
`endif
            end

            if (state_q == ST_NORM) begin
                kept_q   <= w_n ? acc_q[46:24] : acc_q[45:23];
                guard_q  <= w_n ? acc_q[23]    : acc_q[22];
                sticky_q <= w_n ? (|acc_q[22:0]) : (|acc_q[21:0]);
                // 2e - bias + n, kept signed so underflow stays visible.
                er_q     <= {1'b0, exp_q, 1'b0} - 10'(FP_BIAS) + {9'd0, w_n};
            end

            if (state_q == ST_PACK) begin
                sq_q   <= w_packed;
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign sq   = sq_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule
`default_nettype wire
